// File: rtl/booth_seq_mult.sv
// Sequential signed radix-2 Booth multiplier: W+1-bit accumulator, W-bit multiplier shift register.
// Optional BOOTH_SKIP_EN: bypass the add/sub step when the Booth pair is 00 or 11.
module booth_seq_mult #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, OP, SHIFT, DONE} state_t;

  state_t        state, state_nx;
  logic [W:0]    m_reg, a_reg;
  logic [W-1:0]  q_reg;
  logic          q1;
  logic [CW-1:0] cnt;

  logic [W:0]    a_sh;
  logic [W-1:0]  q_sh;
  logic          last;

  // {A,Q,q1} arithmetic shift right by one
  assign a_sh = {a_reg[W], a_reg[W:1]};
  assign q_sh = {a_reg[0], q_reg[W-1:1]};
  assign last = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
`ifdef BOOTH_SKIP_EN
          state_nx = b[0] ? OP : SHIFT;
`else
          state_nx = OP;
`endif
        end
      end
      OP: begin
        busy     = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) begin
          state_nx = DONE;
        end else begin
`ifdef BOOTH_SKIP_EN
          // post-shift pair is {Q[1],Q[0]}; equal pair needs no add/sub
          state_nx = (q_reg[1] == q_reg[0]) ? SHIFT : OP;
`else
          state_nx = OP;
`endif
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg   <= '0;
      a_reg   <= '0;
      q_reg   <= '0;
      q1      <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= {a[W-1], a};
            q_reg <= b;
            a_reg <= '0;
            q1    <= 1'b0;
            cnt   <= CW'(W);
          end
        end
        OP: begin
          case ({q_reg[0], q1})
            2'b10:   a_reg <= a_reg - m_reg;
            2'b01:   a_reg <= a_reg + m_reg;
            default: a_reg <= a_reg;
          endcase
        end
        SHIFT: begin
          a_reg <= a_sh;
          q_reg <= q_sh;
          q1    <= q_reg[0];
          cnt   <= cnt - CW'(1);
          if (last) product <= {a_sh[W-1:0], q_sh};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Scoreboard bench for booth_seq_mult: expected products queued at accept, checked at done.
// Expected latency follows BOOTH_SKIP_EN when the bench is built with it.
module tb_booth_seq_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   op_a, op_b;
  logic           ready, busy, done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  booth_seq_mult #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(op_a), .b(op_b),
    .ready(ready), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] bv);
`ifdef BOOTH_SKIP_EN
    int n = 0;
    logic prev = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (bv[i] != prev) n++;
      prev = bv[i];
    end
    return W + n;
`else
    return 2 * W;
`endif
  endfunction

  task automatic accept(input logic signed [W-1:0] ta, input logic signed [W-1:0] tb_v);
    logic signed [2*W-1:0] p;
    int guard = 0;
    while (!ready && guard < 100) begin @(negedge clk); guard++; end
    chk("ready_before_start", {31'b0, ready}, 32'd1);
    p = ta * tb_v;
    op_a = ta; op_b = tb_v; start = 1'b1;
    exp_q.push_back(p);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // returns negedges after the accept edge until done is seen (0 = cycle right after accept)
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
  endtask

  task automatic run_op(input logic signed [W-1:0] ta, input logic signed [W-1:0] tb_v);
    int cyc;
    logic [2*W-1:0] e;
    accept(ta, tb_v);
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    wait_done(cyc);
    chk("latency", cyc, exp_lat(tb_v));
    e = exp_q.pop_front();
    chk("product", {16'b0, product}, {16'b0, e});
    @(negedge clk);
    chk("done_pulse_width", {31'b0, done}, 32'd0);
    chk("ready_after_done", {31'b0, ready}, 32'd1);
    chk("product_held", {16'b0, product}, {16'b0, e});
  endtask

  initial begin
    int cyc, dc;
    logic [2*W-1:0] e;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_product", {16'b0, product}, 32'h0);

    run_op(8'sd3, 8'sd5);
    run_op(-8'sd7, 8'sd6);
    run_op(-8'sd128, -8'sd128);
    run_op(8'sd127, -8'sd128);
    run_op(8'sh55, 8'sd0);
    for (int i = 0; i < 12; i++) run_op($urandom_range(0, 255), $urandom_range(0, 255));

    // start while busy is ignored
    dc = done_cnt;
    accept(8'sd2, 8'sd3);
    repeat (3) @(negedge clk);
    op_a = 8'd9; op_b = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    e = exp_q.pop_front();
    chk("busy_ignore_product", {16'b0, product}, {16'b0, e});
    repeat (2 * W + 6) @(negedge clk);
    chk("busy_ignore_one_done", done_cnt - dc, 32'd1);
    chk("busy_ignore_idle", {31'b0, ready}, 32'd1);
    chk("busy_ignore_product_held", {16'b0, product}, 32'h0006);

    // reset mid-operation
    dc = done_cnt;
    accept(8'sd7, 8'sd7);
    void'(exp_q.pop_back());
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready", {31'b0, ready}, 32'd1);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    repeat (2 * W + 6) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - dc, 32'd0);
    chk("rst_mid_product", {16'b0, product}, 32'h0);
    run_op(8'sd7, 8'sd7);
    chk("final_7x7", {16'b0, product}, 32'h0031);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_seq_mult.md
# booth_seq_mult

Sequential signed radix-2 Booth multiplier. An FSM sequences a combined accumulator/multiplier shift register through load, add/subtract and arithmetic-shift-right steps. It is the controller/datapath pair that drives the team's shift-register primitives (load, ASR, clear) for multiply operations. Operands are accepted with a start/ready handshake, and the product is returned with a one-cycle done pulse.

## Interface
- W, 8, operand width in bits (two's complement); product is 2W bits
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only on an edge where ready=1
- a  in  W  multiplicand (signed)
- b  in  W  multiplier (signed)
- ready  out  1  high in IDLE only
- busy  out  1  high in OP or SHIFT
- done  out  1  one-cycle pulse; product valid
- product  out  2W  signed a*b; held until next accept or rst

## Operation
- Internal registers:
  - M (W+1 bits), sign-extended a.
  - A (W+1 bits), accumulator.
  - Q (W bits), multiplier, shifted.
  - q1 (1 bit).
  - cnt (log2(W)+1 bits).
- A is W+1 bits so that A-M cannot overflow for a = -2^(W-1).
- States: IDLE, OP, SHIFT, DONE.
- IDLE, on start:
  - M<=sext(a), Q<=b, A<=0, q1<=0, cnt<=W.
  - Go to OP.
  - start while not IDLE is ignored; nothing is queued.
- OP: examine {Q[0],q1}.
  - 10: A<=A-M.
  - 01: A<=A+M.
  - 00/11: A unchanged.
  - Always go to SHIFT.
- SHIFT:
  - {A,Q,q1} <= arithmetic shift right by 1 (A MSB replicated).
  - cnt<=cnt-1.
  - If cnt==1 before the decrement, go to DONE; else go to OP.
- DONE:
  - product<={A[W-1:0],Q}; done=1.
  - Next state is IDLE.
- Arithmetic is modulo 2^(W+1) in A. The product is exact for all operand pairs, including (-2^(W-1))^2.
- rst at any edge:
  - State<=IDLE; A, Q, q1, M, cnt, product<=0.
  - done=0, busy=0; ready=1 in the following cycle.
  - An operation in progress is abandoned with no done pulse.

## Timing
- Reset values: ready=1, busy=0, done=0, product=0.
- Accept edge = edge k, where start=1 and ready=1.
- Without skip, latency is fixed:
  - 2W busy cycles.
  - done high in the cycle after edge k+2W.
  - ready high again after edge k+2W+1.
  - W=8: done is 16 cycles after accept.
- Back-to-back: start may be held high. The next accept is at edge k+2W+2 at the earliest.
- product updates on the same edge that raises done.

## Configuration
- BOOTH_SKIP_EN defined:
  - OP is bypassed whenever the next pair {Q[0],q1} is 00 or 11.
  - IDLE goes directly to SHIFT if b[0]==0.
  - SHIFT loops to SHIFT if the post-shift pair is equal.
  - Latency = W + N cycles to done, where N = number of 10/01 pairs in {b,0}.
  - Results are identical to the non-skip build.
- BOOTH_SKIP_EN undefined: every iteration takes OP+SHIFT, giving fixed 2W latency as above.

## Test plan
- Reset, then idle: ready=1, busy=0, done=0, product=0x0000.
- a=3, b=5 → product 0x000F.
  - Without skip: done 16 cycles after accept.
  - With BOOTH_SKIP_EN: done after 12 cycles (4 ops).
- a=-7, b=6 → 0xFFD6; a=-128, b=-128 → 0x4000; a=127, b=-128 → 0xC080.
- a=0x55, b=0 with BOOTH_SKIP_EN → product 0x0000, done 8 cycles after accept.
- start pulsed with a=9, b=9 while busy on 2*3 → only product 0x0006 is returned, single done pulse, and no second operation follows.
- rst asserted 5 cycles into 7*7 → no done pulse, product=0, ready=1. A new start with a=7, b=7 then yields 0x0031.
